cordic_angle_sched: RTL and testbench

Round-robin scheduler that shares one cordic_angle_calc_kf core between NUM_CH sensor channels. Each channel presents a (cx, cy) int16 sample with a req/ack handshake. The block issues one sample at a time to the core and waits for the core's valid. It then converts the core's first-quadrant angle plus quadrant into a full-circle angle, tags it with the channel index, and returns it on a ready/valid result port. It sits between the per-channel sample front-ends and the shared angle core.

---
 rtl/cordic_angle_sched.sv | 161 ++++++++++++++++
 tb/tb_cordic_angle_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_angle_sched.sv
// Round-robin scheduler that time-shares one angle core between NUM_CH sample channels
// and folds the core's first-quadrant angle plus quadrant into a full-circle result.
//
// state | meaning
// IDLE  | waiting for any ch_req; grants the first requester at or after rr_ptr
// ISSUE | one-cycle core_start pulse, timeout counter cleared
// WAIT  | waiting for core_valid or timeout
// DONE  | result held on res_* until res_ready
module cordic_angle_sched #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      ch_req,
  input  logic [16*NUM_CH-1:0]   ch_cx,
  input  logic [16*NUM_CH-1:0]   ch_cy,
  output logic [NUM_CH-1:0]      ch_ack,
  output logic [15:0]            core_cx,
  output logic [15:0]            core_cy,
  output logic                   core_start,
  input  logic [16:0]            core_theta,
  input  logic [1:0]             core_quad,
  input  logic                   core_valid,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CH_W-1:0]        res_ch,
  output logic [17:0]            res_angle,
  output logic [1:0]             res_quad,
  output logic                   res_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CH_W:0] NUM_CH_W = (CH_W + 1)'(NUM_CH);
  localparam logic signed [18:0] QUAD_STEP = 19'sd51472;
  localparam logic signed [18:0] FULL_TURN = 19'sd205887;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, state_nxt;

  logic [CH_W-1:0]     rr_ptr;
  logic [CH_W-1:0]     cur_ch;
  logic [CH_W-1:0]     gnt_ch;
  logic [CH_W-1:0]     gnt_off;
  logic [CH_W-1:0]     ch_inc;
  logic                gnt_found;
  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0]   req_rot;
  logic [CH_W:0]       gnt_sum;
  logic [CH_W:0]       inc_sum;
  logic [CNT_W-1:0]    cnt;
  logic [15:0]         cx_arr [NUM_CH];
  logic [15:0]         cy_arr [NUM_CH];
  logic signed [18:0]  theta_s;
  logic signed [18:0]  theta_c;
  logic signed [18:0]  full;
  logic signed [18:0]  wrapped;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign cx_arr[i] = ch_cx[16*i +: 16];
    assign cy_arr[i] = ch_cy[16*i +: 16];
  end

  // Rotate requests so bit 0 is rr_ptr, pick the lowest set bit, then rotate back.
  always_comb begin
    req_dbl   = {ch_req, ch_req};
    req_rot   = NUM_CH'(req_dbl >> rr_ptr);
    gnt_found = 1'b0;
    gnt_off   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        gnt_found = 1'b1;
        gnt_off   = CH_W'(i);
      end
    end
    gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_off};
    gnt_ch  = (gnt_sum >= NUM_CH_W) ? CH_W'(gnt_sum - NUM_CH_W) : CH_W'(gnt_sum);
    inc_sum = {1'b0, cur_ch} + (CH_W + 1)'(1);
    ch_inc  = (inc_sum >= NUM_CH_W) ? CH_W'(inc_sum - NUM_CH_W) : CH_W'(inc_sum);
  end

  always_comb begin
    theta_s = {{2{core_theta[16]}}, core_theta};
    theta_c = (theta_s < 0) ? 19'sd0 : theta_s;
    full    = $signed({17'd0, core_quad}) * QUAD_STEP + theta_c;
    wrapped = (full >= FULL_TURN) ? full - FULL_TURN : full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_start = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE:  if (gnt_found) state_nxt = ISSUE;
      ISSUE: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:  if (core_valid || cnt == CNT_LAST) state_nxt = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_ack      <= '0;
      core_cx     <= '0;
      core_cy     <= '0;
      cur_ch      <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      res_angle   <= '0;
      res_quad    <= '0;
      res_timeout <= 1'b0;
    end else begin
      ch_ack <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            ch_ack  <= NUM_CH'(1) << gnt_ch;
            core_cx <= cx_arr[gnt_ch];
            core_cy <= cy_arr[gnt_ch];
            cur_ch  <= gnt_ch;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          // A valid in the terminal-count cycle still counts as a real result.
          if (core_valid) begin
            res_angle   <= wrapped[17:0];
            res_quad    <= core_quad;
            res_timeout <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            res_angle   <= '0;
            res_quad    <= '0;
            res_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: if (res_ready) rr_ptr <= ch_inc;
        default: ;
      endcase
    end
  end

  assign res_ch = cur_ch;

endmodule

// File: tb/tb_cordic_angle_sched.sv
// Directed bench for cordic_angle_sched: latency, angle folding, round-robin order,
// timeout, result backpressure and mid-transaction reset.
module tb_cordic_angle_sched;
  localparam int NUM_CH = 4;
  localparam int CH_W = 2;
  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ch_req;
  logic [63:0] ch_cx;
  logic [63:0] ch_cy;
  logic [3:0]  ch_ack;
  logic [15:0] core_cx;
  logic [15:0] core_cy;
  logic        core_start;
  logic [16:0] core_theta;
  logic [1:0]  core_quad;
  logic        core_valid;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_ch;
  logic [17:0] res_angle;
  logic [1:0]  res_quad;
  logic        res_timeout;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;

  cordic_angle_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req(ch_req), .ch_cx(ch_cx), .ch_cy(ch_cy), .ch_ack(ch_ack),
    .core_cx(core_cx), .core_cy(core_cy), .core_start(core_start),
    .core_theta(core_theta), .core_quad(core_quad), .core_valid(core_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_angle(res_angle), .res_quad(res_quad), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) ack_cnt = ack_cnt + $countones(ch_ack);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output logic [3:0] ack);
    int n = 0;
    while (ch_ack == 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ack = ch_ack;
    if (ch_ack == 4'd0) chk("ack_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic core_resp(input logic [16:0] th, input logic [1:0] q);
    core_valid = 1'b1;
    core_theta = th;
    core_quad  = q;
    @(negedge clk);
    core_valid = 1'b0;
    core_theta = '0;
    core_quad  = '0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  int th_tab [3] = '{25736, 51472, -5};
  int q_tab  [3] = '{3, 3, 0};
  int ex_tab [3] = '{180152, 1, 0};

  initial begin
    logic [3:0] ack;
    int n;
    int bad;
    int ack_base;
    int exp_ch;

    rst_n = 1'b0; ch_req = '0; ch_cx = '0; ch_cy = '0;
    core_theta = '0; core_quad = '0; core_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ch_ack), 32'd0);
    chk("rst_core_cx", 32'(core_cx), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_angle", 32'(res_angle), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single uncontended request, core answers after 20 WAIT cycles.
    ch_cx[15:0] = 16'd1000;
    ch_req = 4'b0001;
    @(negedge clk);
    chk("t1_ack", 32'(ch_ack), 32'd1);
    chk("t1_core_cx", 32'(core_cx), 32'd1000);
    chk("t1_start", 32'(core_start), 32'd1);
    ch_req = '0;
    @(negedge clk);
    chk("t1_ack_pulse", 32'(ch_ack), 32'd0);
    chk("t1_start_pulse", 32'(core_start), 32'd0);
    repeat (19) @(negedge clk);
    core_resp(17'd0, 2'd0);
    chk("t1_res_valid", 32'(res_valid), 32'd1);
    chk("t1_res_ch", 32'(res_ch), 32'd0);
    chk("t1_res_angle", 32'(res_angle), 32'd0);
    chk("t1_res_timeout", 32'(res_timeout), 32'd0);
    accept();
    chk("t1_valid_drop", 32'(res_valid), 32'd0);

    // Angle folding, always on ch3 so rr_ptr ends at 0.
    for (int k = 0; k < 3; k++) begin
      ch_cx[63:48] = 16'(k + 7);
      ch_req = 4'b1000;
      @(negedge clk);
      ch_req = '0;
      chk("ang_ack", 32'(ch_ack), 32'd8);
      @(negedge clk);
      core_resp(17'(th_tab[k]), 2'(q_tab[k]));
      chk("ang_value", 32'(res_angle), 32'(ex_tab[k]));
      chk("ang_quad", 32'(res_quad), 32'(q_tab[k]));
      accept();
    end

    // Round-robin with all channels held high.
    for (int i = 0; i < 4; i++) ch_cx[16*i +: 16] = 16'(100 * (i + 1));
    ack_base = ack_cnt;
    res_ready = 1'b1;
    ch_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_ch = k % 4;
      wait_ack(ack);
      chk("rr_ack", 32'(ack), 32'(1 << exp_ch));
      chk("rr_core_cx", 32'(core_cx), 32'(100 * (exp_ch + 1)));
      @(negedge clk);
      core_resp(17'(k * 10), 2'd0);
      chk("rr_res_ch", 32'(res_ch), 32'(exp_ch));
      chk("rr_res_angle", 32'(res_angle), 32'(k * 10));
      if (k == 4) ch_req = '0;
    end
    @(negedge clk);
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rr_ack_count", 32'(ack_cnt - ack_base), 32'd5);

    // Timeout on ch1 (rr_ptr is 1 now).
    ch_req = 4'b0010;
    wait_ack(ack);
    chk("to_ack", 32'(ack), 32'd2);
    ch_req = '0;
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", 32'(n), 32'd65);
    chk("to_flag", 32'(res_timeout), 32'd1);
    chk("to_angle", 32'(res_angle), 32'd0);
    chk("to_res_ch", 32'(res_ch), 32'd1);
    accept();
    core_resp(17'd100, 2'd1);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid || core_start) bad++;
    end
    chk("to_stale_valid", 32'(bad), 32'd0);

    // Backpressure in DONE while ch1 requests.
    ch_cx[47:32] = 16'd555;
    ch_req = 4'b0100;
    wait_ack(ack);
    chk("bp_ack", 32'(ack), 32'd4);
    ch_req = '0;
    @(negedge clk);
    core_resp(17'd777, 2'd1);
    chk("bp_angle", 32'(res_angle), 32'd52249);
    chk("bp_quad", 32'(res_quad), 32'd1);
    ch_cx[31:16] = 16'd222;
    ch_req = 4'b0010;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid || res_angle != 18'd52249 || res_ch != 2'd2 || ch_ack != 4'd0) bad++;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    accept();
    chk("bp_valid_drop", 32'(res_valid), 32'd0);
    chk("bp_no_early_ack", 32'(ch_ack), 32'd0);
    @(negedge clk);
    chk("bp_late_ack", 32'(ch_ack), 32'd2);
    chk("bp_core_cx", 32'(core_cx), 32'd222);
    ch_req = '0;

    // Reset during WAIT; rr_ptr was 3 and must return to 0.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_core_cx", 32'(core_cx), 32'd0);
    chk("mr_ack", 32'(ch_ack), 32'd0);
    chk("mr_start", 32'(core_start), 32'd0);
    chk("mr_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    core_resp(17'd50, 2'd2);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (res_valid || core_start) bad++;
    end
    chk("mr_stale_valid", 32'(bad), 32'd0);
    ch_req = 4'b1100;
    wait_ack(ack);
    chk("mr_regrant", 32'(ack), 32'd4);
    ch_req = '0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
